// File: rtl/lcm_seq_if.sv
// Handshake and operand/result bundle for the sequential LCM/GCD engine.
// The master issues operand pairs; the slave (the engine) returns gcd and lcm.
interface lcm_seq_if #(
  parameter int unsigned W = 4
);
  logic           start;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           busy;
  logic           done;
  logic [W-1:0]   g;
  logic [2*W-1:0] lcm;

  modport master (
    output start, x, y,
    input  busy, done, g, lcm
  );

  modport slave (
    input  start, x, y,
    output busy, done, g, lcm
  );
endinterface

// File: rtl/lcm_seq.sv
// Multi-cycle LCM/GCD engine with a start/done handshake.
// gcd is found by binary (Stein) reduction, one step per clock, then
// lcm = (x / g) * y using restoring division followed by shift-add multiply.
// W must be at least 2.
module lcm_seq #(
  parameter int unsigned W = 4
) (
  input logic       clk,
  input logic       rst,
  lcm_seq_if.slave  bus
);

  localparam int unsigned KW = $clog2(W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGcd,
    StRestore,
    StDiv,
    StMul,
    StDone
  } state_e;

  state_e         state_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   g_q;
  logic [2*W-1:0] lcm_q;

  // Captured operands, kept for the divide and multiply phases.
  logic [W-1:0]   xa_q;
  logic [W-1:0]   yb_q;

  // Stein reduction working registers; k counts the shared factors of two.
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [KW-1:0]  k_q;

  // Divide/multiply datapath: quotient doubles as the dividend shift register
  // during DIV and as the multiplier shift register during MUL.
  logic [W-1:0]   quo_q;
  logic [W-1:0]   rem_q;
  logic [2*W-1:0] prod_q;
  logic [2*W-1:0] mcand_q;
  logic [KW-1:0]  cnt_q;

  logic [W:0]     rem_shift;
  logic           q_bit;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic [2*W-1:0] prod_next;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.g    = g_q;
  assign bus.lcm  = lcm_q;

  // One restoring-division step and one shift-add step, from current registers.
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    q_bit     = (rem_shift >= {1'b0, g_q});
    rem_next  = q_bit ? W'(rem_shift - {1'b0, g_q}) : rem_shift[W-1:0];
    quo_next  = (quo_q << 1) | W'(q_bit);
    prod_next = quo_q[0] ? (prod_q + mcand_q) : prod_q;
  end

  // Controller and datapath; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= '0;
      lcm_q   <= '0;
      xa_q    <= '0;
      yb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            xa_q   <= bus.x;
            yb_q   <= bus.y;
            a_q    <= bus.x;
            b_q    <= bus.y;
            k_q    <= '0;
            busy_q <= 1'b1;
            if ((bus.x == '0) || (bus.y == '0)) begin
              g_q     <= bus.x | bus.y;
              lcm_q   <= '0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StGcd;
            end
          end
        end

        StGcd: begin
          if (a_q == b_q) begin
            state_q <= StRestore;
          end else if (!a_q[0] && !b_q[0]) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + KW'(1);
          end else if (!a_q[0]) begin
            a_q <= a_q >> 1;
          end else if (!b_q[0]) begin
            b_q <= b_q >> 1;
          end else if (a_q >= b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end

        StRestore: begin
          g_q     <= a_q << k_q;
          quo_q   <= xa_q;
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= StDiv;
        end

        StDiv: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          if (cnt_q == KW'(W - 1)) begin
            prod_q  <= '0;
            mcand_q <= {{W{1'b0}}, yb_q};
            cnt_q   <= '0;
            state_q <= StMul;
          end else begin
            cnt_q <= cnt_q + KW'(1);
          end
        end

        StMul: begin
          prod_q  <= prod_next;
          mcand_q <= mcand_q << 1;
          quo_q   <= quo_q >> 1;
          if (cnt_q == KW'(W - 1)) begin
            lcm_q   <= prod_next;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + KW'(1);
          end
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_seq.sv
// Self-checking bench for lcm_seq: directed cases, mid-run reset, ignored
// start while busy, and a shuffled exhaustive sweep against a software model.
module tb_lcm_seq;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lcm_seq_if #(.W(W)) bus ();

  lcm_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid gcd, lcm by plain arithmetic, and the Stein step count
  // obtained by applying the reduction rules to the numbers directly.
  task automatic ref_model(input int ax, input int ay, output int eg, output int el,
                           output int en);
    int p, q, t, a, b;
    p = ax;
    q = ay;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    eg = p;
    el = (ax == 0 || ay == 0) ? 0 : (ax * ay) / eg;
    en = 0;
    if (ax != 0 && ay != 0) begin
      a = ax;
      b = ay;
      while (a != b) begin
        if (a % 2 == 0 && b % 2 == 0) begin
          a = a / 2;
          b = b / 2;
        end else if (a % 2 == 0) begin
          a = a / 2;
        end else if (b % 2 == 0) begin
          b = b / 2;
        end else if (a > b) begin
          a = a - b;
        end else begin
          b = b - a;
        end
        en++;
      end
    end
  endtask

  // Call at a negedge. Issues one operation; optionally pulses a stray start
  // (3,5) at negedge index 'inject' after acceptance. Returns with the bench
  // at the negedge after done, i.e. in the first IDLE cycle.
  task automatic run_op(input int ax, input int ay, input int inject, output int lat);
    int eg, el, en, exp_lat;
    logic found;
    ref_model(ax, ay, eg, el, en);
    exp_lat = (ax == 0 || ay == 0) ? 0 : en + 2 + 2 * W;
    bus.start = 1'b1;
    bus.x     = 4'(ax);
    bus.y     = 4'(ay);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = 4'($urandom);
    bus.y     = 4'($urandom);
    found = 1'b0;
    lat   = -1;
    for (int i = 0; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (i == 0) check_eq("busy_in_flight", 32'(bus.busy), 32'd1);
      if (i == inject) begin
        bus.start = 1'b1;
        bus.x     = 4'd3;
        bus.y     = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check_eq($sformatf("gcd(%0d,%0d)", ax, ay), 32'(bus.g), 32'(eg));
    check_eq($sformatf("lcm(%0d,%0d)", ax, ay), 32'(bus.lcm), 32'(el));
    check_eq($sformatf("latency(%0d,%0d)", ax, ay), 32'(lat), 32'(exp_lat));
    check_eq("latency_bound", 32'(lat >= 0 && lat <= 6 * W + 2), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
    check_eq("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  int lat;
  int done_cnt;
  int order [256];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_g", 32'(bus.g), 32'd0);
    check_eq("rst_lcm", 32'(bus.lcm), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4, 6, -1, lat);
    check_eq("lat_4_6", 32'(lat), 32'd14);
    run_op(15, 15, -1, lat);
    check_eq("lat_15_15", 32'(lat), 32'd10);
    run_op(15, 14, -1, lat);
    run_op(0, 9, -1, lat);
    check_eq("lat_zero", 32'(lat), 32'd0);
    run_op(0, 0, -1, lat);

    // Stray start while busy must be dropped.
    run_op(12, 8, 2, lat);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_eq("ignored_start_done", 32'(done_cnt), 32'd0);
    check_eq("ignored_start_busy", 32'(bus.busy), 32'd0);
    check_eq("ignored_start_g", 32'(bus.g), 32'd4);
    check_eq("ignored_start_lcm", 32'(bus.lcm), 32'd24);

    // Reset in flight clears outputs asynchronously.
    bus.start = 1'b1;
    bus.x     = 4'd14;
    bus.y     = 4'd10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_g", 32'(bus.g), 32'd0);
    check_eq("midrst_lcm", 32'(bus.lcm), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(9, 6, -1, lat);

    // Exhaustive sweep in shuffled order, back-to-back.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      run_op(order[i] / 16, order[i] % 16, -1, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcm_seq.md
# lcm_seq

Multi-cycle LCM/GCD engine with a start/done handshake. It computes gcd(x, y) with binary (Stein) reduction, one step per clock, then forms lcm = (x / g) * y. The division is restoring and the multiplication is shift-add. The block is the clocked, handshaked counterpart of the team's combinational GCD datapath: a controller issues operand pairs and collects both results when `done` pulses.

## Interface
- `W`, default 4: operand width; `g` is W bits, `lcm` is 2W bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `x`  in  W: operand A, captured on the accepted `start` edge.
- `y`  in  W: operand B, captured on the accepted `start` edge.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse; results are valid while it is high.
- `g`  out  W: gcd(x, y), held until the next accepted `start`.
- `lcm`  out  2W: lcm(x, y), held until the next accepted `start`.

## Operation
- Reset values:
  - state = IDLE
  - `busy` = 0, `done` = 0, `g` = 0, `lcm` = 0
  - internal a, b, k, quotient, remainder and product registers = 0
- **IDLE**
  - `start` = 1: latch xa = x, yb = y, a = x, b = y, k = 0.
  - If x == 0 or y == 0: load g = x | y and lcm = 0, then go to DONE.
  - Otherwise go to GCD.
- **GCD** (one step per cycle):
  - a == b: go to RESTORE, no register change.
  - a, b both even: a >>= 1, b >>= 1, k += 1.
  - Only a even: a >>= 1. Only b even: b >>= 1.
  - Both odd: subtract the smaller from the larger (a ≥ b gives a −= b, else b −= a).
- **RESTORE**: g = a << k in a single cycle; go to DIV.
- **DIV**: restoring division q = xa / g, one quotient bit per cycle, MSB first, W cycles. The remainder is always 0 at the end; this is not checked in RTL.
- **MUL**: shift-add p = q * yb, one multiplier bit per cycle, W cycles, 2W-bit accumulator with no overflow (q ≤ 2^W − 1). At exit, lcm = p.
- **DONE**: `done` = 1 for exactly this cycle; next state is IDLE unconditionally.
- Width rules:
  - k fits in ceil(log2(W+1)) bits; k ≤ W−1 for nonzero operands.
  - a and b are W bits and never underflow: subtraction is only performed larger-minus-smaller.
- `start` in any non-IDLE state, including DONE, is ignored; there is no queueing.
- Changes on x and y after the accepted edge have no effect.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs cleared; the in-flight result is discarded.
  - After deassertion, the first `start` is accepted normally.

## Timing
- Accepted `start` at edge E0; N = number of GCD steps executed.
- Nonzero operands:
  - GCD occupies N+1 cycles, RESTORE 1, DIV W, MUL W.
  - `done` is high in the cycle following edge E0+N+2+2W.
  - `busy` is high from E0 through the end of the DONE cycle.
- Zero operand: `done` is high in the cycle directly after E0, i.e. 1-cycle latency.
- N bound: ≤ 4W; total latency ≤ 6W+2 cycles.
- A new `start` may be accepted in the first IDLE cycle after DONE, giving a minimum of 1 idle cycle between `done` and the next acceptance.
- `g` and `lcm` update only on RESTORE exit (for `g`), MUL exit (for `lcm`), or on the IDLE zero path. They are stable whenever `busy` = 0.

## Test plan
- x=4, y=6 → N=4; `done` visible after E0+14; g=2, lcm=12; `busy` low the following cycle.
- x=15, y=15 → N=0; `done` after E0+10; g=15, lcm=15. Also x=15, y=14 → g=1, lcm=210.
- x=0, y=9 → g=9, lcm=0, `done` the cycle after E0. Also x=0, y=0 → g=0, lcm=0.
- x=12, y=8 (exercises k=2) → g=4, lcm=24. Pulse `start` with x=3, y=5 while busy: it must be ignored, with results still 4/24 and exactly one `done` pulse.
- x=14, y=10: assert `rst` 3 cycles after `start`. Outputs go to 0 asynchronously and the state goes to IDLE. After release, x=9, y=6 → g=3, lcm=18.
- Exhaustive sweep of all 256 (x, y) pairs at W=4, back-to-back starts. Each result must match the software gcd/lcm. Latency must be ≤ 26 cycles, and `done` must never be wider than 1 cycle.
